regfile_dump_reader: RTL and testbench

- Debug snapshot engine for the 16-bit core's register file.
- On `start`, asks the core to halt and waits for acknowledge.
- Then reads every register through a dedicated register-file read port and streams `{index, value}` words over a valid/ready interface toward the debug/host link.
- Acts as the reader at the other end of the register-file write path; the core resumes after the last word is accepted.

---
 rtl/regfile_dump_reader_pkg.sv | 22 ++
 rtl/regfile_dump_reader.sv | 118 +++++++++++
 tb/tb_regfile_dump_reader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump engine: widths, register count
// and the dump sequencer state encoding.
package regfile_dump_reader_pkg;

   localparam int unsigned DATA_WIDTH    = 16;
   localparam int unsigned NUM_REGISTERS = 16;
   localparam int unsigned REG_ADDR_W    = $clog2(NUM_REGISTERS);

   typedef enum logic [2:0] {
      IDLE,
      HALT_WAIT,
      READ,
      SEND,
      FINISH
   } dump_state_t;

   // Holding the core is required while the file is being read or streamed.
   function automatic logic holds_core(input dump_state_t s);
      return (s == HALT_WAIT) || (s == READ) || (s == SEND);
   endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Debug snapshot engine: halts the core, walks the register file through its
// read port and streams {index, value} words over a valid/ready link.
module regfile_dump_reader
   import regfile_dump_reader_pkg::*;
#(
   parameter int unsigned HALT_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  halt_req,
   input  logic                  halt_ack,
   output logic [REG_ADDR_W-1:0] rf_ra,
   input  logic [DATA_WIDTH-1:0] rf_rd,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [REG_ADDR_W-1:0] out_idx,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last
);

   localparam int unsigned TIMER_W = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(HALT_TIMEOUT - 1);
   localparam logic [REG_ADDR_W-1:0] IDX_LAST   = REG_ADDR_W'(NUM_REGISTERS - 1);

   dump_state_t           state, state_n;
   logic [REG_ADDR_W-1:0] idx, idx_n;
   logic [TIMER_W-1:0]    timer, timer_n;
   logic                  error_n;
   logic [DATA_WIDTH-1:0] data_n;
   logic [REG_ADDR_W-1:0] oidx_n;

   // Next-state and next-datapath decode.
   always_comb begin
      state_n = state;
      idx_n   = idx;
      timer_n = timer;
      error_n = error;
      data_n  = out_data;
      oidx_n  = out_idx;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = HALT_WAIT;
               error_n = 1'b0;
               timer_n = '0;
               idx_n   = '0;
            end
         end
         HALT_WAIT: begin
            if (halt_ack) begin
               state_n = READ;
            end else if (timer == TIMER_LAST) begin
               error_n = 1'b1;
               state_n = FINISH;
            end else begin
               timer_n = timer + TIMER_W'(1);
            end
         end
         READ: begin
            data_n  = rf_rd;
            oidx_n  = idx;
            state_n = SEND;
         end
         SEND: begin
            if (out_ready) begin
               if (idx == IDX_LAST) begin
                  state_n = FINISH;
               end else begin
                  idx_n   = idx + REG_ADDR_W'(1);
                  state_n = READ;
               end
            end
         end
         FINISH: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // All outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         idx       <= '0;
         timer     <= '0;
         error     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         halt_req  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         rf_ra     <= '0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         timer     <= timer_n;
         error     <= error_n;
         busy      <= (state_n != IDLE);
         done      <= (state_n == FINISH);
         halt_req  <= holds_core(state_n);
         out_valid <= (state_n == SEND);
         out_last  <= (state_n == SEND) && (idx_n == IDX_LAST);
         out_data  <= data_n;
         out_idx   <= oidx_n;
         rf_ra     <= idx_n;
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: table of dump scenarios plus
// randomized runs, checked against a cycle-count/queue reference.
module tb_regfile_dump_reader;
   import regfile_dump_reader_pkg::*;

   localparam int unsigned HT = 8;
   localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGISTERS - 1);

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic                  busy;
   logic                  done;
   logic                  error;
   logic                  halt_req;
   logic                  halt_ack;
   logic [REG_ADDR_W-1:0] rf_ra;
   logic [DATA_WIDTH-1:0] rf_rd;
   logic [DATA_WIDTH-1:0] out_data;
   logic [REG_ADDR_W-1:0] out_idx;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;

   logic [DATA_WIDTH-1:0] rf_mem [NUM_REGISTERS];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int ack_cycle;   // first cycle (start cycle = 0) halt_ack is high; -1 = never
      int ready_mode;  // 0 always ready, 1 one-in-three, 2 random
      bit rand_rf;
      bit exp_err;
      int exp_words;
      int exp_first;   // cycle of first out_valid; -1 = none
   } vec_t;

   regfile_dump_reader #(.HALT_TIMEOUT(HT)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .error(error), .halt_req(halt_req), .halt_ack(halt_ack),
      .rf_ra(rf_ra), .rf_rd(rf_rd), .out_data(out_data), .out_idx(out_idx),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
   );

   always #5 clk = ~clk;

   // Register file read port: R0 is hardwired to zero.
   assign rf_rd = (rf_ra == '0) ? '0 : rf_mem[rf_ra];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DATA_WIDTH-1:0] exp_val(input int k);
      logic [REG_ADDR_W-1:0] a;
      a = k[REG_ADDR_W-1:0];
      return (k == 0) ? '0 : rf_mem[a];
   endfunction

   function automatic logic ready_for(input int mode, input int c);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (c % 3) == 2;
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic load_rf(input bit rnd);
      for (int i = 0; i < NUM_REGISTERS; i++)
         rf_mem[i] = rnd ? DATA_WIDTH'($urandom) : DATA_WIDTH'(16'h1000 + i);
      rf_mem[0] = 16'hFFFF;
   endtask

   // Runs one dump from cycle 0 (start presented) up to the done cycle.
   task automatic run_dump(input vec_t v, input bit hold_start);
      int c, first, done_c, last_acc, nwords, hreq;
      bit stall_bad, last_bad, word_bad, busy_bad, prev_stall;
      logic [DATA_WIDTH-1:0] pd;
      logic [REG_ADDR_W-1:0] pi;
      c = 0; first = -1; done_c = -1; last_acc = -1; nwords = 0; hreq = 0;
      stall_bad = 0; last_bad = 0; word_bad = 0; busy_bad = 0; prev_stall = 0;
      pd = '0; pi = '0;
      start     = 1'b1;
      halt_ack  = (v.ack_cycle == 0);
      out_ready = ready_for(v.ready_mode, 0);
      while (done_c < 0 && c < 400) begin
         step();
         c++;
         if (!hold_start) start = 1'b0;
         if (c == 1) chk("error_cleared_at_start", 32'(error), 0);
         if (!busy) busy_bad = 1;
         if (halt_req) hreq++;
         if (prev_stall && (!out_valid || out_data !== pd || out_idx !== pi)) stall_bad = 1;
         if (out_valid) begin
            if (first < 0) first = c;
            if (out_last !== (out_idx == LAST_IDX)) last_bad = 1;
         end else if (out_last) begin
            last_bad = 1;
         end
         halt_ack  = (v.ack_cycle >= 0) && (c >= v.ack_cycle);
         out_ready = ready_for(v.ready_mode, c);
         if (out_valid && out_ready) begin
            if (nwords >= NUM_REGISTERS || out_idx !== REG_ADDR_W'(nwords) ||
                out_data !== exp_val(nwords)) word_bad = 1;
            nwords++;
            last_acc = c;
         end
         prev_stall = out_valid && !out_ready;
         pd = out_data;
         pi = out_idx;
         if (done) done_c = c;
      end
      chk("done_seen", 32'(done), 1);
      chk("word_count", nwords, v.exp_words);
      chk("first_valid_cycle", first, v.exp_first);
      chk("error_at_done", 32'(error), 32'(v.exp_err));
      chk("stall_stable", 32'(stall_bad), 0);
      chk("last_flag", 32'(last_bad), 0);
      chk("word_content_order", 32'(word_bad), 0);
      chk("busy_during_dump", 32'(busy_bad), 0);
      chk("halt_req_cycles", hreq, done_c - 1);
      if (v.exp_err) begin
         chk("timeout_halt_cycles", hreq, HT);
      end else begin
         chk("done_after_last_word", done_c, last_acc + 1);
         if (v.ready_mode == 0)
            chk("full_rate_done_cycle", done_c, first + 2 * (NUM_REGISTERS - 1) + 1);
      end
      if (!hold_start) begin
         step();
         chk("done_single_pulse", 32'(done), 0);
         chk("idle_after_finish", 32'(busy), 0);
         chk("error_held_in_idle", 32'(error), 32'(v.exp_err));
      end
   endtask

   vec_t vecs [7];

   initial begin
      int n;
      vec_t rv;
      vecs[0] = '{ack_cycle: 0,  ready_mode: 0, rand_rf: 0, exp_err: 0, exp_words: 16, exp_first: 3};
      vecs[1] = '{ack_cycle: 0,  ready_mode: 1, rand_rf: 0, exp_err: 0, exp_words: 16, exp_first: 3};
      vecs[2] = '{ack_cycle: -1, ready_mode: 0, rand_rf: 0, exp_err: 1, exp_words: 0,  exp_first: -1};
      vecs[3] = '{ack_cycle: 0,  ready_mode: 0, rand_rf: 1, exp_err: 0, exp_words: 16, exp_first: 3};
      vecs[4] = '{ack_cycle: 5,  ready_mode: 0, rand_rf: 0, exp_err: 0, exp_words: 16, exp_first: 7};
      vecs[5] = '{ack_cycle: 2,  ready_mode: 2, rand_rf: 1, exp_err: 0, exp_words: 16, exp_first: 4};
      vecs[6] = '{ack_cycle: 1,  ready_mode: 2, rand_rf: 1, exp_err: 0, exp_words: 16, exp_first: 3};

      rst = 1'b0; start = 1'b0; halt_ack = 1'b0; out_ready = 1'b0;
      load_rf(0);
      #12;
      chk("reset_outputs", 32'({busy, done, error, halt_req, out_valid, out_last,
                                out_data, out_idx, rf_ra}), 0);
      step();
      rst = 1'b1;
      step();

      for (int i = 0; i < 7; i++) begin
         load_rf(vecs[i].rand_rf);
         run_dump(vecs[i], 0);
      end

      // Randomized ack latency and backpressure.
      for (int i = 0; i < 4; i++) begin
         rv.ack_cycle  = int'($urandom_range(0, 6));
         rv.ready_mode = 2;
         rv.rand_rf    = 1;
         rv.exp_err    = 0;
         rv.exp_words  = NUM_REGISTERS;
         rv.exp_first  = ((rv.ack_cycle < 1) ? 1 : rv.ack_cycle) + 2;
         load_rf(1);
         run_dump(rv, 0);
      end

      // Asynchronous reset while streaming idx 6.
      load_rf(0);
      start = 1'b1; halt_ack = 1'b1; out_ready = 1'b1;
      n = 0;
      step();
      start = 1'b0;
      while (!(out_valid && out_idx == REG_ADDR_W'(6)) && n < 200) begin
         step();
         n++;
      end
      chk("reached_idx6", 32'(out_idx), 6);
      #1;
      rst = 1'b0;
      #1;
      chk("async_reset_outputs", 32'({busy, done, error, halt_req, out_valid, out_last,
                                      out_data, out_idx, rf_ra}), 0);
      n = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (done || busy) n++;
      end
      chk("no_done_in_reset", n, 0);
      rst = 1'b1;
      step();
      run_dump(vecs[0], 0);

      // start held high: one dump, one IDLE cycle, then a second dump.
      run_dump(vecs[0], 1);
      step();
      chk("held_start_idle_gap", 32'(busy), 0);
      step();
      chk("held_start_restart_busy", 32'(busy), 1);
      chk("held_start_restart_halt", 32'(halt_req), 1);
      start = 1'b0;
      n = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         step();
         if (out_valid && out_idx == REG_ADDR_W'(n) && out_data === exp_val(n)) n++;
      end
      chk("held_start_second_dump_words", n, NUM_REGISTERS);
      chk("held_start_second_done", 32'(done), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
